xadc_drp_sched: RTL and testbench
=================================

# xadc_drp_sched

Sequencer and arbiter for the XADC dynamic reconfiguration port (DRP). It shares the single DRP between a host requester (bus-side register access) and an internal periodic scanner. The scanner reads the temperature, VCCINT, VCCAUX and VBRAM status registers and caches them as always-valid sensor outputs. It sits between the Wishbone XADC wrapper logic and the XADC primitive.

## Interface
Parameters:
- SCAN_PERIOD, 100000: cycles between scan starts; minimum 16.
- TIMEOUT, 255: maximum cycles to wait for DRDY; only used with the timeout feature; minimum 4.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- scan_en_i  in  1  enables the periodic scan timer.
- host_req_i  in  1  host request; held until host_ack_o or host_err_o.
- host_we_i  in  1  host write (1) or read (0).
- host_addr_i  in  7  DRP address.
- host_dat_i  in  16  write data.
- host_dat_o  out  16  read data; valid with host_ack_o.
- host_ack_o  out  1  one-cycle completion pulse.
- host_err_o  out  1  one-cycle error pulse.
- drp_den_o  out  1  DRP enable; one-cycle pulse.
- drp_dwe_o, drp_daddr_o[6:0], drp_di_o[15:0]  out  DRP write enable, address and data; valid with drp_den_o.
- drp_do_i  in  16  DRP read data.
- drp_drdy_i  in  1  DRP data ready.
- jtag_locked_i  in  1  JTAG holds the DRP lock.
- temp_o, vccint_o, vccaux_o, vbram_o  out  12 each  cached readings, taken from drp_do_i[15:4].
- scan_valid_o  out  1  high once a full scan has completed.
- scan_done_o  out  1  one-cycle pulse when a scan completes.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: choose a requester when host_req_i or scan_pending is set.
  - If both are pending, grant the one not granted last (last_grant flag, reset value = scan).
  - host_req_i is ignored in the cycle host_ack_o or host_err_o is high.
- ISSUE: drp_den_o=1 for exactly one cycle, with address, data and dwe for the grantee; then go to WAIT.
- WAIT: on drp_drdy_i, capture drp_do_i and go to RESP.
  - drp_drdy_i outside WAIT is ignored.
  - Host writes also wait for DRDY.
- RESP (one cycle):
  - Host: host_ack_o=1 and host_dat_o=captured data (0 for writes).
  - Scanner: write drp_do_i[15:4] into the cache slot for the current index, then increment the index.
  - Then go to IDLE.
- Scan list: index 0..3 → address 0x00 (temp), 0x01 (vccint), 0x02 (vccaux), 0x06 (vbram).
  - Each entry is a separate transaction; host requests can interleave between entries.
  - After index 3 completes: clear scan_pending, pulse scan_done_o, set scan_valid_o, reset the index to 0.
- Scan timer:
  - Down-counter; runs only while scan_en_i=1 and holds its value otherwise.
  - On reaching 0 it reloads SCAN_PERIOD-1 and sets scan_pending.
  - A tick while a scan is pending or in progress is dropped.
- JTAG lock: while jtag_locked_i=1, IDLE issues no grant.
  - A pending host request gets host_err_o (one cycle) the cycle after it is seen in IDLE.
  - scan_pending is held until the lock releases.
  - A transaction already in WAIT completes normally.

## Timing
- Reset values: all outputs 0, state IDLE, scan index 0, timer SCAN_PERIOD-1, scan_pending 0, last_grant = scan.
- Reset mid-transaction abandons it; a late DRDY after reset is ignored.
- Host latency:
  - req seen in IDLE at cycle n.
  - DEN at n+1.
  - DRDY at n+1+d, where d ≥ 1.
  - ack at n+2+d.
- Minimum host round trip: 4 cycles.
- A back-to-back host request is re-granted in IDLE 1 cycle after ack, unless the scanner wins the alternation.
- Cache outputs change only in a scanner RESP cycle.
- scan_done_o coincides with the RESP of index 3.

## Configuration
- XADC_DRP_TIMEOUT_EN defined: WAIT counts cycles. If TIMEOUT cycles pass without DRDY, go to IDLE.
  - Host grantee: host_err_o pulse.
  - Scanner grantee: abort the scan; index returns to 0, scan_pending clears, cache and scan_valid_o are unchanged, no scan_done_o.
- Not defined: WAIT waits indefinitely and no counter logic is generated.

## Structure
- Package xadc_drp_sched_pkg holds:
  - state enum;
  - scan address constants (0x00, 0x01, 0x02, 0x06);
  - scan list length 4;
  - result slice [15:4].
- One sub-module, xadc_scan_timer: period counter, scan_en_i gating and tick output.

## Test plan
- Single host read of 0x00, DRDY 3 cycles after DEN, drp_do_i=0xABC0: host_ack_o 1 cycle after DRDY with host_dat_o=0xABC0; exactly one DEN pulse.
- SCAN_PERIOD=16, scan_en_i=1, model returns 0x1230/0x4560/0x7890/0xABC0: four DENs to 0x00, 0x01, 0x02, 0x06; then temp_o=0x123, vccint_o=0x456, vccaux_o=0x789, vbram_o=0xABC; scan_done_o one pulse; scan_valid_o=1.
- Host request held continuously during a scan: DEN addresses alternate scan/host/scan/host…; no starvation; the scan completes.
- jtag_locked_i=1 with host_req_i=1: host_err_o pulse, no DEN. Release the lock: the pending scan issues.
- With XADC_DRP_TIMEOUT_EN, TIMEOUT=8, no DRDY on a host read: host_err_o 8 cycles after entering WAIT, state returns to IDLE. Repeat on a scanner read: index resets, no scan_done_o.
- wb_rst_i asserted in WAIT, then DRDY arrives: no ack, no cache update, all outputs 0.

Source files
------------

// File: rtl/xadc_drp_sched_pkg.sv
// Shared types and constants for the XADC DRP scheduler: FSM state codes,
// grant owner, scan address list and the slice of DRP data kept as a reading.
package xadc_drp_sched_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef enum logic {
    GRANT_SCAN = 1'b0,
    GRANT_HOST = 1'b1
  } grant_t;

  localparam int SCAN_LEN = 4;

  localparam logic [6:0] ADDR_TEMP   = 7'h00;
  localparam logic [6:0] ADDR_VCCINT = 7'h01;
  localparam logic [6:0] ADDR_VCCAUX = 7'h02;
  localparam logic [6:0] ADDR_VBRAM  = 7'h06;

  localparam int RES_MSB = 15;
  localparam int RES_LSB = 4;

  function automatic logic [6:0] scan_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    scan_addr = ADDR_TEMP;
      2'd1:    scan_addr = ADDR_VCCINT;
      2'd2:    scan_addr = ADDR_VCCAUX;
      default: scan_addr = ADDR_VBRAM;
    endcase
  endfunction

endpackage

// File: rtl/xadc_scan_timer.sv
// Periodic scan timer: a down-counter that only advances while scan_en_i is
// high and emits tick_o in the cycle it sits at zero, then reloads.
module xadc_scan_timer #(
  parameter int SCAN_PERIOD = 100000
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic scan_en_i,
  output logic tick_o
);

  localparam int CW = $clog2(SCAN_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(SCAN_PERIOD - 1);

  logic [CW-1:0] count;

  assign tick_o = scan_en_i && (count == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count <= RELOAD;
    end else if (scan_en_i) begin
      if (count == '0) count <= RELOAD;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/xadc_drp_sched.sv
// XADC DRP arbiter/sequencer: shares the DRP between a host requester and a
// periodic sensor scanner. Optional DRDY timeout: define XADC_DRP_TIMEOUT_EN.
module xadc_drp_sched
  import xadc_drp_sched_pkg::*;
#(
  parameter int SCAN_PERIOD = 100000,
  parameter int TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        scan_en_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [6:0]  host_addr_i,
  input  logic [15:0] host_dat_i,
  output logic [15:0] host_dat_o,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  input  logic        jtag_locked_i,
  output logic [11:0] temp_o,
  output logic [11:0] vccint_o,
  output logic [11:0] vccaux_o,
  output logic [11:0] vbram_o,
  output logic        scan_valid_o,
  output logic        scan_done_o,
  output logic [1:0]  dbg_state_o
);

  if (SCAN_PERIOD < 16 || TIMEOUT < 4) begin : g_bad_param
    $error("xadc_drp_sched: SCAN_PERIOD must be >= 16 and TIMEOUT >= 4");
  end

  // Handshakes: host_req_i is a level the requester holds until it sees the
  // one-cycle host_ack_o or host_err_o; it is ignored in that cycle. The DRP
  // side is a one-cycle drp_den_o answered later by a one-cycle drp_drdy_i.

  state_t        state;
  grant_t        grant;
  grant_t        last_grant;
  logic          cur_we;
  logic [6:0]    cur_addr;
  logic [15:0]   cur_di;
  logic [15:0]   rdata;
  logic [1:0]    scan_idx;
  logic          scan_pending;
  logic          err_q;
  logic          tick;
  logic          host_req_eff;
  logic          pick_host;
  logic          pick_scan;
  logic          scan_last;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] wait_cnt;
`endif

  xadc_scan_timer #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .scan_en_i (scan_en_i),
    .tick_o    (tick)
  );

  assign host_req_eff = host_req_i && !host_ack_o && !err_q;
  // On contention the requester that did not win last time gets the DRP.
  assign pick_host    = host_req_eff && (!scan_pending || last_grant == GRANT_SCAN);
  assign pick_scan    = scan_pending && !pick_host;
  assign scan_last    = (scan_idx == 2'(SCAN_LEN - 1));

  assign drp_den_o   = (state == ST_ISSUE);
  assign drp_dwe_o   = drp_den_o && cur_we;
  assign drp_daddr_o = drp_den_o ? cur_addr : 7'h00;
  assign drp_di_o    = drp_den_o ? cur_di : 16'h0000;

  assign host_ack_o  = (state == ST_RESP) && (grant == GRANT_HOST);
  assign host_dat_o  = (host_ack_o && !cur_we) ? rdata : 16'h0000;
  assign host_err_o  = err_q;
  assign scan_done_o = (state == ST_RESP) && (grant == GRANT_SCAN) && scan_last;
  assign dbg_state_o = state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      grant        <= GRANT_SCAN;
      last_grant   <= GRANT_SCAN;
      cur_we       <= 1'b0;
      cur_addr     <= 7'h00;
      cur_di       <= 16'h0000;
      rdata        <= 16'h0000;
      scan_idx     <= 2'd0;
      scan_pending <= 1'b0;
      scan_valid_o <= 1'b0;
      err_q        <= 1'b0;
      temp_o       <= 12'h000;
      vccint_o     <= 12'h000;
      vccaux_o     <= 12'h000;
      vbram_o      <= 12'h000;
`ifdef XADC_DRP_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      // A tick while a scan is pending or running is dropped; scan_pending
      // stays set until the last entry (or an abort), so it covers both.
      if (tick && !scan_pending) scan_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (jtag_locked_i) begin
            if (host_req_eff) err_q <= 1'b1;
          end else if (pick_host) begin
            grant      <= GRANT_HOST;
            last_grant <= GRANT_HOST;
            cur_we     <= host_we_i;
            cur_addr   <= host_addr_i;
            cur_di     <= host_dat_i;
            state      <= ST_ISSUE;
          end else if (pick_scan) begin
            grant      <= GRANT_SCAN;
            last_grant <= GRANT_SCAN;
            cur_we     <= 1'b0;
            cur_addr   <= scan_addr(scan_idx);
            cur_di     <= 16'h0000;
            state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
`ifdef XADC_DRP_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (drp_drdy_i) begin
            rdata <= drp_do_i;
            state <= ST_RESP;
          end
`ifdef XADC_DRP_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state <= ST_IDLE;
            if (grant == GRANT_HOST) begin
              err_q <= 1'b1;
            end else begin
              scan_idx     <= 2'd0;
              scan_pending <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          state <= ST_IDLE;
          if (grant == GRANT_SCAN) begin
            case (scan_idx)
              2'd0:    temp_o   <= rdata[RES_MSB:RES_LSB];
              2'd1:    vccint_o <= rdata[RES_MSB:RES_LSB];
              2'd2:    vccaux_o <= rdata[RES_MSB:RES_LSB];
              default: vbram_o  <= rdata[RES_MSB:RES_LSB];
            endcase
            if (scan_last) begin
              scan_idx     <= 2'd0;
              scan_pending <= 1'b0;
              scan_valid_o <= 1'b1;
            end else begin
              scan_idx <= scan_idx + 2'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Directed bench for xadc_drp_sched: stimulus pushes expected DEN, host
// response and cache records into queues; a monitor pops and compares them.
module tb_xadc_drp_sched;
  import xadc_drp_sched_pkg::*;

  localparam int SCAN_PERIOD = 16;
  localparam int TIMEOUT     = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        scan_en_i;
  logic        host_req_i;
  logic        host_we_i;
  logic [6:0]  host_addr_i;
  logic [15:0] host_dat_i;
  logic [15:0] host_dat_o;
  logic        host_ack_o;
  logic        host_err_o;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i;
  logic        drp_drdy_i;
  logic        jtag_locked_i;
  logic [11:0] temp_o, vccint_o, vccaux_o, vbram_o;
  logic        scan_valid_o;
  logic        scan_done_o;
  logic [1:0]  dbg_state_o;

  xadc_drp_sched #(
    .SCAN_PERIOD (SCAN_PERIOD),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .scan_en_i     (scan_en_i),
    .host_req_i    (host_req_i),
    .host_we_i     (host_we_i),
    .host_addr_i   (host_addr_i),
    .host_dat_i    (host_dat_i),
    .host_dat_o    (host_dat_o),
    .host_ack_o    (host_ack_o),
    .host_err_o    (host_err_o),
    .drp_den_o     (drp_den_o),
    .drp_dwe_o     (drp_dwe_o),
    .drp_daddr_o   (drp_daddr_o),
    .drp_di_o      (drp_di_o),
    .drp_do_i      (drp_do_i),
    .drp_drdy_i    (drp_drdy_i),
    .jtag_locked_i (jtag_locked_i),
    .temp_o        (temp_o),
    .vccint_o      (vccint_o),
    .vccaux_o      (vccaux_o),
    .vbram_o       (vbram_o),
    .scan_valid_o  (scan_valid_o),
    .scan_done_o   (scan_done_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_den_q[$];    // {dwe, addr, di}
  logic [16:0] exp_host_q[$];   // {err, data}
  logic [47:0] exp_cache_q[$];  // {temp, vccint, vccaux, vbram}
  int checks = 0;
  int errors = 0;
  int last_den_cyc = 0;
  int last_resp_cyc = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [47:0] act);
    checks++;
    errors++;
    $display("FAIL %s got unexpected %h expected nothing", name, act);
  endtask

  // DRP model: answers each DEN after drdy_delay cycles with tbl[addr].
  logic [15:0] tbl [0:127];
  int drdy_delay = 1;
  bit drdy_en = 1'b1;

  initial begin
    logic [15:0] rsp;
    int n;
    drp_drdy_i = 1'b0;
    drp_do_i   = 16'h0000;
    forever begin
      @(negedge wb_clk_i);
      if (drp_den_o && drdy_en) begin
        rsp = tbl[drp_daddr_o];
        n   = drdy_delay;
        repeat (n) @(posedge wb_clk_i);
        #1;
        drp_drdy_i = 1'b1;
        drp_do_i   = rsp;
        @(posedge wb_clk_i);
        #1;
        drp_drdy_i = 1'b0;
        drp_do_i   = 16'h0000;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    logic [23:0] e_den;
    logic [16:0] e_host;
    logic [47:0] e_cache;
    bit cache_chk;
    cache_chk = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (cache_chk) begin
        cache_chk = 1'b0;
        e_cache = exp_cache_q.pop_front();
        check("cache", {temp_o, vccint_o, vccaux_o, vbram_o}, e_cache);
        check("scan_valid", 48'(scan_valid_o), 48'd1);
      end
      if (drp_den_o) begin
        last_den_cyc = cyc;
        if (exp_den_q.size() == 0) begin
          fail_unexpected("den", {drp_dwe_o, drp_daddr_o, drp_di_o});
        end else begin
          e_den = exp_den_q.pop_front();
          check("den", {drp_dwe_o, drp_daddr_o, drp_di_o}, e_den);
        end
      end
      if (host_ack_o || host_err_o) begin
        last_resp_cyc = cyc;
        if (exp_host_q.size() == 0) begin
          fail_unexpected("host_resp", {host_ack_o, host_err_o, host_dat_o});
        end else begin
          e_host = exp_host_q.pop_front();
          check("host_resp", {host_ack_o, host_err_o, host_dat_o},
                {~e_host[16], e_host[16], e_host[15:0]});
        end
      end
      if (scan_done_o) begin
        if (exp_cache_q.size() == 0) fail_unexpected("scan_done", 48'd1);
        else cache_chk = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_txn(input logic we, input logic [6:0] a, input logic [15:0] d);
    int n;
    @(posedge wb_clk_i);
    #1;
    host_req_i  = 1'b1;
    host_we_i   = we;
    host_addr_i = a;
    host_dat_i  = d;
    for (n = 0; n < 300; n++) begin
      @(negedge wb_clk_i);
      if (host_ack_o || host_err_o) break;
    end
    if (n >= 300) fail_unexpected("host_txn_timeout", 48'(a));
    host_req_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge wb_clk_i);
      if (scan_done_o) break;
    end
    if (n >= budget) fail_unexpected("scan_done_timeout", 48'(budget));
  endtask

  task automatic wait_den(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge wb_clk_i);
      if (drp_den_o) break;
    end
    if (n >= budget) fail_unexpected("den_timeout", 48'(budget));
  endtask

  task automatic push_scan(input logic [47:0] cache);
    exp_den_q.push_back({1'b0, 7'h00, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h01, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h02, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h06, 16'h0000});
    exp_cache_q.push_back(cache);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_host"}, {host_ack_o, host_err_o, host_dat_o}, 48'd0);
    check({tag, "_drp"}, {drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o}, 48'd0);
    check({tag, "_cache"}, {temp_o, vccint_o, vccaux_o, vbram_o}, 48'd0);
    check({tag, "_scan"}, {scan_valid_o, scan_done_o}, 48'd0);
    check({tag, "_state"}, 48'(dbg_state_o), 48'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    wb_rst_i      = 1'b1;
    scan_en_i     = 1'b0;
    host_req_i    = 1'b0;
    host_we_i     = 1'b0;
    host_addr_i   = 7'h00;
    host_dat_i    = 16'h0000;
    jtag_locked_i = 1'b0;
    for (int i = 0; i < 128; i++) tbl[i] = 16'h0000;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_all_zero("reset");

    // Single host read, DRDY 3 cycles after DEN: ack 4 cycles after DEN.
    tbl[7'h00] = 16'hABC0;
    drdy_delay = 3;
    exp_den_q.push_back({1'b0, 7'h00, 16'h0000});
    exp_host_q.push_back({1'b0, 16'hABC0});
    host_txn(1'b0, 7'h00, 16'h0000);
    check("read_latency", 48'(last_resp_cyc - last_den_cyc), 48'd4);

    // Host write: data returned is 0, write still waits for DRDY.
    drdy_delay = 1;
    exp_den_q.push_back({1'b1, 7'h41, 16'h1234});
    exp_host_q.push_back({1'b0, 16'h0000});
    host_txn(1'b1, 7'h41, 16'h1234);
    check("write_latency", 48'(last_resp_cyc - last_den_cyc), 48'd2);

    // Full scan on its own.
    tbl[7'h00] = 16'h1230;
    tbl[7'h01] = 16'h4560;
    tbl[7'h02] = 16'h7890;
    tbl[7'h06] = 16'hABC0;
    check("valid_before_scan", 48'(scan_valid_o), 48'd0);
    push_scan({12'h123, 12'h456, 12'h789, 12'hABC});
    @(posedge wb_clk_i);
    #1 scan_en_i = 1'b1;
    wait_done(100);
    scan_en_i = 1'b0;
    @(negedge wb_clk_i);

    // Host held continuously across a scan: grants alternate S/H/S/H/S/H/S.
    tbl[7'h00] = 16'h1110;
    tbl[7'h01] = 16'h2220;
    tbl[7'h02] = 16'h3330;
    tbl[7'h06] = 16'h4440;
    tbl[7'h10] = 16'h5550;
    exp_den_q.push_back({1'b0, 7'h00, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h10, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h01, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h10, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h02, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h10, 16'h0000});
    exp_den_q.push_back({1'b0, 7'h06, 16'h0000});
    exp_cache_q.push_back({12'h111, 12'h222, 12'h333, 12'h444});
    repeat (3) exp_host_q.push_back({1'b0, 16'h5550});
    @(posedge wb_clk_i);
    #1 scan_en_i = 1'b1;
    wait_den(40);
    scan_en_i   = 1'b0;
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 7'h10;
    host_dat_i  = 16'h0000;
    acks = 0;
    for (int n = 0; n < 300 && acks < 3; n++) begin
      @(negedge wb_clk_i);
      if (host_ack_o || host_err_o) acks++;
    end
    host_req_i = 1'b0;
    check("interleave_acks", 48'(acks), 48'd3);
    wait_done(60);
    @(negedge wb_clk_i);

    // JTAG lock: host gets an error, no DEN; pending scan runs after release.
    jtag_locked_i = 1'b1;
    @(posedge wb_clk_i);
    #1 scan_en_i = 1'b1;
    repeat (25) @(negedge wb_clk_i);
    scan_en_i = 1'b0;
    exp_host_q.push_back({1'b1, 16'h0000});
    host_txn(1'b0, 7'h10, 16'h0000);
    repeat (10) @(negedge wb_clk_i);
    check("locked_state", 48'(dbg_state_o), 48'(ST_IDLE));
    check("locked_no_den", 48'(exp_den_q.size()), 48'd0);
    tbl[7'h00] = 16'h0010;
    tbl[7'h01] = 16'h0020;
    tbl[7'h02] = 16'h0030;
    tbl[7'h06] = 16'h0040;
    push_scan({12'h001, 12'h002, 12'h003, 12'h004});
    @(posedge wb_clk_i);
    #1 jtag_locked_i = 1'b0;
    wait_done(60);
    @(negedge wb_clk_i);

`ifdef XADC_DRP_TIMEOUT_EN
    // Host read with no DRDY: error TIMEOUT cycles after entering WAIT.
    drdy_en = 1'b0;
    exp_den_q.push_back({1'b0, 7'h20, 16'h0000});
    exp_host_q.push_back({1'b1, 16'h0000});
    host_txn(1'b0, 7'h20, 16'h0000);
    check("timeout_latency", 48'(last_resp_cyc - last_den_cyc), 48'(TIMEOUT + 1));
    @(negedge wb_clk_i);
    check("timeout_state", 48'(dbg_state_o), 48'(ST_IDLE));

    // Scanner read with no DRDY: scan aborts, no retry, cache kept.
    exp_den_q.push_back({1'b0, 7'h00, 16'h0000});
    @(posedge wb_clk_i);
    #1 scan_en_i = 1'b1;
    wait_den(40);
    scan_en_i = 1'b0;
    repeat (25) @(negedge wb_clk_i);
    check("abort_cache", {temp_o, vccint_o, vccaux_o, vbram_o},
          {12'h001, 12'h002, 12'h003, 12'h004});
    check("abort_valid", 48'(scan_valid_o), 48'd1);
    check("abort_state", 48'(dbg_state_o), 48'(ST_IDLE));

    // Next scan restarts from index 0.
    drdy_en = 1'b1;
    tbl[7'h00] = 16'h0050;
    push_scan({12'h005, 12'h002, 12'h003, 12'h004});
    @(posedge wb_clk_i);
    #1 scan_en_i = 1'b1;
    wait_done(60);
    scan_en_i = 1'b0;
    @(negedge wb_clk_i);
`endif

    // Reset while in WAIT; the late DRDY must be ignored.
    drdy_delay = 8;
    tbl[7'h30] = 16'hFFF0;
    exp_den_q.push_back({1'b0, 7'h30, 16'h0000});
    @(posedge wb_clk_i);
    #1;
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 7'h30;
    wait_den(20);
    host_req_i = 1'b0;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    repeat (12) @(negedge wb_clk_i);
    check_all_zero("mid_reset");

    // ---------------- final report ----------------
    check("den_q_empty", 48'(exp_den_q.size()), 48'd0);
    check("host_q_empty", 48'(exp_host_q.size()), 48'd0);
    check("cache_q_empty", 48'(exp_cache_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
